and_nand_xnor_gates: RTL and testbench

// - Registered bitwise logic-gate bank: AND, NAND and XNOR of two WIDTH-bit operands, computed together.
// - Adds per-vector reduction flags and an optional equality-event counter.
// - Used as a small datapath primitive wherever gated or compared operand pairs feed clocked logic.

---
 rtl/and_nand_xnor_gates.sv | 74 +++++++
 tb/tb_and_nand_xnor_gates.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/and_nand_xnor_gates.sv
// Registered AND/NAND/XNOR gate bank with all-ones/equality reduction flags.
// Optional saturating equality-event counter enabled by macro GATE_EQCNT_EN.
module and_nand_xnor_gates #(
    parameter int unsigned WIDTH = 1
`ifdef GATE_EQCNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_xnor,
    output logic             all_and,
    output logic             all_eq
`ifdef GATE_EQCNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] eq_count
`endif
);

    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] xnor_d;

    always_comb begin
        and_d  = a & b;
        xnor_d = ~(a ^ b);
    end

    // y_nand is registered separately so that reset drives it to 0, not ~0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y_and     <= '0;
            y_nand    <= '0;
            y_xnor    <= '0;
            all_and   <= 1'b0;
            all_eq    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_and   <= and_d;
                y_nand  <= ~and_d;
                y_xnor  <= xnor_d;
                all_and <= &and_d;
                all_eq  <= &xnor_d;
            end
        end
    end

`ifdef GATE_EQCNT_EN
    logic eq_hit;

    always_comb begin
        eq_hit = in_valid & (&xnor_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_count <= '0;
        end else if (cnt_clr) begin
            eq_count <= '0;
        end else if (eq_hit && (eq_count != '1)) begin
            eq_count <= eq_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_and_nand_xnor_gates.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances share stimulus and are
// compared every cycle against a bit-level behavioural model plus fixed vectors.
module tb_and_nand_xnor_gates;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;

    logic       ov8, aa8, ae8;
    logic [7:0] ya8, yn8, yx8;
    logic       ov1, aa1, ae1;
    logic [0:0] ya1, yn1, yx1;

`ifdef GATE_EQCNT_EN
    logic        cnt_clr;
    logic [1:0]  cnt8;
    logic [15:0] cnt1;
    int          m_cnt8;
    int          m_cnt1;
`endif

    and_nand_xnor_gates #(
        .WIDTH(8)
`ifdef GATE_EQCNT_EN
        , .CNT_W(2)
`endif
    ) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov8), .y_and(ya8), .y_nand(yn8), .y_xnor(yx8),
        .all_and(aa8), .all_eq(ae8)
`ifdef GATE_EQCNT_EN
        , .cnt_clr(cnt_clr), .eq_count(cnt8)
`endif
    );

    and_nand_xnor_gates #(
        .WIDTH(1)
`ifdef GATE_EQCNT_EN
        , .CNT_W(16)
`endif
    ) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .out_valid(ov1), .y_and(ya1), .y_nand(yn1), .y_xnor(yx1),
        .all_and(aa1), .all_eq(ae1)
`ifdef GATE_EQCNT_EN
        , .cnt_clr(cnt_clr), .eq_count(cnt1)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (expected outputs of the WIDTH=8 instance).
    logic       m_v;
    logic [7:0] m_and, m_nand, m_xnor;
    logic       m_aa, m_ae;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_and;
        logic [7:0] e_nand;
        logic [7:0] e_xnor;
        logic       e_aa;
        logic       e_ae;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_and = '0; m_nand = '0; m_xnor = '0; m_aa = 1'b0; m_ae = 1'b0;
`ifdef GATE_EQCNT_EN
        m_cnt8 = 0; m_cnt1 = 0;
`endif
    endtask

    // Bit-by-bit arithmetic view of the gates; reductions from whole-vector compares.
    task automatic model_edge();
        int ai, bi;
`ifdef GATE_EQCNT_EN
        if (cnt_clr) begin
            m_cnt8 = 0;
            m_cnt1 = 0;
        end else if (in_valid) begin
            if (a == b && m_cnt8 < 3) m_cnt8 = m_cnt8 + 1;
            if (a[0] == b[0] && m_cnt1 < 65535) m_cnt1 = m_cnt1 + 1;
        end
`endif
        m_v = in_valid;
        if (in_valid) begin
            for (int i = 0; i < 8; i++) begin
                ai = int'(a[i]);
                bi = int'(b[i]);
                m_and[i]  = (ai * bi == 1);
                m_nand[i] = (ai * bi == 0);
                m_xnor[i] = (ai == bi);
            end
            m_aa = (a == 8'hFF) && (b == 8'hFF);
            m_ae = (a == b);
        end
    endtask

    task automatic check_all();
        chk("ov8", 32'(ov8), 32'(m_v));
        chk("y_and8", 32'(ya8), 32'(m_and));
        chk("y_nand8", 32'(yn8), 32'(m_nand));
        chk("y_xnor8", 32'(yx8), 32'(m_xnor));
        chk("all_and8", 32'(aa8), 32'(m_aa));
        chk("all_eq8", 32'(ae8), 32'(m_ae));
        chk("ov1", 32'(ov1), 32'(m_v));
        chk("y_and1", 32'(ya1), 32'(m_and[0]));
        chk("y_nand1", 32'(yn1), 32'(m_nand[0]));
        chk("y_xnor1", 32'(yx1), 32'(m_xnor[0]));
        chk("all_and1", 32'(aa1), 32'(m_and[0]));
        chk("all_eq1", 32'(ae1), 32'(m_xnor[0]));
`ifdef GATE_EQCNT_EN
        chk("eq_count8", 32'(cnt8), 32'(m_cnt8));
        chk("eq_count1", 32'(cnt1), 32'(m_cnt1));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'hF0, 8'h3C, 8'h30, 8'hCF, 8'h33, 1'b0, 1'b0};
        vecs[6] = '{8'h0F, 8'h0E, 8'h0E, 8'hF1, 8'hFE, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
`ifdef GATE_EQCNT_EN
        cnt_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Fixed vectors: truth table (bit 0 feeds WIDTH=1) and 8-bit patterns.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
            tick();
            chk("vec_ov", 32'(ov8), 32'd1);
            chk("vec_and", 32'(ya8), 32'(vecs[i].e_and));
            chk("vec_nand", 32'(yn8), 32'(vecs[i].e_nand));
            chk("vec_xnor", 32'(yx8), 32'(vecs[i].e_xnor));
            chk("vec_all_and", 32'(aa8), 32'(vecs[i].e_aa));
            chk("vec_all_eq", 32'(ae8), 32'(vecs[i].e_ae));
            chk("vec1_and", 32'(ya1), 32'(vecs[i].e_and[0]));
            chk("vec1_nand", 32'(yn1), 32'(vecs[i].e_nand[0]));
            chk("vec1_xnor", 32'(yx1), 32'(vecs[i].e_xnor[0]));
        end

        // Hold: in_valid low with new operands keeps previous results.
        in_valid = 1'b1; a = 8'hA5; b = 8'h0F;
        tick();
        in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
        tick();
        chk("hold_ov", 32'(ov8), 32'd0);
        chk("hold_and", 32'(ya8), 32'h05);
        chk("hold_nand", 32'(yn8), 32'hFA);
        chk("hold_xnor", 32'(yx8), 32'h55);
        tick();

        // Async reset between edges, in-flight pair discarded.
        in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
        tick();
        rst_pulse();
        chk("rst_nand", 32'(yn8), 32'h00);
        in_valid = 1'b1; a = 8'h55; b = 8'h55;
        tick();
        chk("post_rst_ov", 32'(ov8), 32'd1);
        chk("post_rst_eq", 32'(ae8), 32'd1);

`ifdef GATE_EQCNT_EN
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = a;
            tick();
            chk("sat_seq", 32'(cnt8), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        cnt_clr = 1'b1; a = 8'h3C; b = 8'h3C;
        tick();
        chk("clr_prio", 32'(cnt8), 32'd0);
        cnt_clr = 1'b0;
`endif

        // Randomized traffic with frequent equal pairs and occasional resets.
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
`ifdef GATE_EQCNT_EN
            cnt_clr = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 63) == 0) rst_pulse();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
